// File: rtl/fp_result_wb.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_wb
// Purpose  : Merges fp_add_sub and fp_mul results onto the FP register-file
//            write port, buffering displaced adds and keeping sticky fflags.
// Options  : FP_WB_BYPASS_EN - uncontended adds skip the FIFO (1-cycle path)
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_wb #(
    parameter int RV    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          add_valid,
    input  logic          add_hart,
    input  logic [5:0]    add_rd,
    input  logic [RV-1:0] add_res,
    input  logic [4:0]    add_flags,
    input  logic          mul_valid,
    input  logic          mul_hart,
    input  logic [5:0]    mul_rd,
    input  logic [RV-1:0] mul_res,
    input  logic [4:0]    mul_flags,
    output logic          add_stall,
    output logic          wb_valid,
    output logic          wb_hart,
    output logic [5:0]    wb_rd,
    output logic [RV-1:0] wb_res,
    input  logic          csr_we,
    input  logic          csr_hart,
    input  logic [4:0]    csr_data,
    output logic [4:0]    fflags_0,
    output logic [4:0]    fflags_1
);

    localparam int             AW        = $clog2(DEPTH);
    localparam int             PW        = AW + 1;
    localparam logic [PW-1:0]  FULL_LVL  = PW'(DEPTH);
    localparam logic [PW-1:0]  STALL_LVL = PW'(DEPTH - 1);

    // FIFO storage: flags travel alongside the result
    logic          mem_hart_q  [DEPTH];
    logic [5:0]    mem_rd_q    [DEPTH];
    logic [RV-1:0] mem_res_q   [DEPTH];
    logic [4:0]    mem_flags_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          add_stall_q, add_stall_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_hart_q, wb_hart_d;
    logic [5:0]    wb_rd_q, wb_rd_d;
    logic [RV-1:0] wb_res_q, wb_res_d;
    logic [4:0]    fflags_0_q, fflags_0_d;
    logic [4:0]    fflags_1_q, fflags_1_d;

    logic          fifo_empty, fifo_full;
    logic          push, push_ok, pop;
    logic          sel_valid, sel_hart;
    logic [5:0]    sel_rd;
    logic [RV-1:0] sel_res;
    logic [4:0]    sel_flags;
    logic [4:0]    retire_0, retire_1;
    logic [AW-1:0] wr_idx, rd_idx;

    assign count_q    = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_LVL);
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];

    // Writeback selection: mul first, then FIFO head, then a fresh add
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_hart  = 1'b0;
        sel_rd    = '0;
        sel_res   = '0;
        sel_flags = '0;
        if (mul_valid) begin
            sel_valid = 1'b1;
            sel_hart  = mul_hart;
            sel_rd    = mul_rd;
            sel_res   = mul_res;
            sel_flags = mul_flags;
            push      = add_valid;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_hart  = mem_hart_q[rd_idx];
            sel_rd    = mem_rd_q[rd_idx];
            sel_res   = mem_res_q[rd_idx];
            sel_flags = mem_flags_q[rd_idx];
            push      = add_valid;
        end else if (add_valid) begin
`ifdef FP_WB_BYPASS_EN
            sel_valid = 1'b1;
            sel_hart  = add_hart;
            sel_rd    = add_rd;
            sel_res   = add_res;
            sel_flags = add_flags;
`else
            push      = 1'b1;
`endif
        end
    end

    // A full FIFO only accepts a push when the head leaves in the same cycle
    assign push_ok = push && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push_ok);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = wr_ptr_d - rd_ptr_d;
        add_stall_d = (count_d >= STALL_LVL);

        wb_valid_d  = sel_valid;
        wb_hart_d   = sel_valid ? sel_hart : wb_hart_q;
        wb_rd_d     = sel_valid ? sel_rd   : wb_rd_q;
        wb_res_d    = sel_valid ? sel_res  : wb_res_q;

        retire_0    = (sel_valid && !sel_hart) ? sel_flags : 5'b0;
        retire_1    = (sel_valid &&  sel_hart) ? sel_flags : 5'b0;
        fflags_0_d  = ((csr_we && !csr_hart) ? csr_data : fflags_0_q) | retire_0;
        fflags_1_d  = ((csr_we &&  csr_hart) ? csr_data : fflags_1_q) | retire_1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            add_stall_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_hart_q   <= 1'b0;
            wb_rd_q     <= '0;
            wb_res_q    <= '0;
            fflags_0_q  <= '0;
            fflags_1_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            add_stall_q <= add_stall_d;
            wb_valid_q  <= wb_valid_d;
            wb_hart_q   <= wb_hart_d;
            wb_rd_q     <= wb_rd_d;
            wb_res_q    <= wb_res_d;
            fflags_0_q  <= fflags_0_d;
            fflags_1_q  <= fflags_1_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_hart_q[wr_idx]  <= add_hart;
            mem_rd_q[wr_idx]    <= add_rd;
            mem_res_q[wr_idx]   <= add_res;
            mem_flags_q[wr_idx] <= add_flags;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (push && !push_ok) begin
            $display("fp_result_wb overflow");
        end
    end
`endif

    assign add_stall = add_stall_q;
    assign wb_valid  = wb_valid_q;
    assign wb_hart   = wb_hart_q;
    assign wb_rd     = wb_rd_q;
    assign wb_res    = wb_res_q;
    assign fflags_0  = fflags_0_q;
    assign fflags_1  = fflags_1_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_wb.sv
`default_nettype none
// Testbench for fp_result_wb: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_fp_result_wb;
    localparam int RV    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          add_valid, add_hart;
    logic [5:0]    add_rd;
    logic [RV-1:0] add_res;
    logic [4:0]    add_flags;
    logic          mul_valid, mul_hart;
    logic [5:0]    mul_rd;
    logic [RV-1:0] mul_res;
    logic [4:0]    mul_flags;
    logic          add_stall, wb_valid, wb_hart;
    logic [5:0]    wb_rd;
    logic [RV-1:0] wb_res;
    logic          csr_we, csr_hart;
    logic [4:0]    csr_data;
    logic [4:0]    fflags_0, fflags_1;

    int n_cmp = 0;
    int n_bad = 0;

    fp_result_wb #(.RV(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .add_valid(add_valid), .add_hart(add_hart), .add_rd(add_rd),
        .add_res(add_res), .add_flags(add_flags),
        .mul_valid(mul_valid), .mul_hart(mul_hart), .mul_rd(mul_rd),
        .mul_res(mul_res), .mul_flags(mul_flags),
        .add_stall(add_stall), .wb_valid(wb_valid), .wb_hart(wb_hart),
        .wb_rd(wb_rd), .wb_res(wb_res),
        .csr_we(csr_we), .csr_hart(csr_hart), .csr_data(csr_data),
        .fflags_0(fflags_0), .fflags_1(fflags_1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic          hart;
        logic [5:0]    rd;
        logic [RV-1:0] res;
        logic [4:0]    flags;
    } ent_t;

    ent_t          pend[$];
    logic          m_valid, m_hart, m_stall;
    logic [5:0]    m_rd;
    logic [RV-1:0] m_res;
    logic [4:0]    m_ff0, m_ff1;

    function automatic logic [RV-1:0] resv(input int rd);
        return 64'hffffffff_3f800000 + 64'(rd);
    endfunction

    task automatic model_reset();
        pend.delete();
        m_valid = 0; m_hart = 0; m_rd = 0; m_res = 0;
        m_ff0 = 0; m_ff1 = 0; m_stall = 0;
    endtask

    task automatic model_step();
        ent_t a, s;
        bit   sv;
        sv = 0;
        a = '{add_hart, add_rd, add_res, add_flags};
        s = '{1'b0, 6'd0, '0, 5'd0};
        if (mul_valid) begin
            s = '{mul_hart, mul_rd, mul_res, mul_flags};
            sv = 1;
            if (add_valid) pend.push_back(a);
        end else if (pend.size() > 0) begin
            s = pend.pop_front();
            sv = 1;
            if (add_valid) pend.push_back(a);
        end else if (add_valid) begin
`ifdef FP_WB_BYPASS_EN
            s = a;
            sv = 1;
`else
            pend.push_back(a);
`endif
        end
        if (csr_we && !csr_hart) m_ff0 = csr_data;
        if (csr_we &&  csr_hart) m_ff1 = csr_data;
        if (sv && !s.hart) m_ff0 = m_ff0 | s.flags;
        if (sv &&  s.hart) m_ff1 = m_ff1 | s.flags;
        m_valid = sv;
        if (sv) begin
            m_hart = s.hart; m_rd = s.rd; m_res = s.res;
        end
        m_stall = (pend.size() >= DEPTH - 1);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_valid));
        check({tag, ".wb_hart"},  64'(wb_hart),  64'(m_hart));
        check({tag, ".wb_rd"},    64'(wb_rd),    64'(m_rd));
        check({tag, ".wb_res"},   wb_res,        m_res);
        check({tag, ".fflags_0"}, 64'(fflags_0), 64'(m_ff0));
        check({tag, ".fflags_1"}, 64'(fflags_1), 64'(m_ff1));
        check({tag, ".add_stall"}, 64'(add_stall), 64'(m_stall));
    endtask

    task automatic idle();
        add_valid = 0; add_hart = 0; add_rd = 0; add_res = 0; add_flags = 0;
        mul_valid = 0; mul_hart = 0; mul_rd = 0; mul_res = 0; mul_flags = 0;
        csr_we = 0; csr_hart = 0; csr_data = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       mv, mh;
        logic [5:0] mrd;
        logic [4:0] mf;
        logic       av, ah;
        logic [5:0] ard;
        logic [4:0] af;
        logic       ev, eh;
        logic [5:0] erd;
        logic       es;
        logic [4:0] ef0, ef1;
    } vec_t;

    function automatic vec_t mk(input int mv, mh, mrd, mf, av, ah, ard, af,
                                input int ev, eh, erd, es, ef0, ef1);
        vec_t v;
        v.mv = 1'(mv); v.mh = 1'(mh); v.mrd = 6'(mrd); v.mf = 5'(mf);
        v.av = 1'(av); v.ah = 1'(ah); v.ard = 6'(ard); v.af = 5'(af);
        v.ev = 1'(ev); v.eh = 1'(eh); v.erd = 6'(erd); v.es = 1'(es);
        v.ef0 = 5'(ef0); v.ef1 = 5'(ef1);
        return v;
    endfunction

    vec_t tbl[19];

    initial begin
        // mul+add collision, then drain
        tbl[0]  = mk(1,0, 3,2,  1,0, 4,1,  1,0, 3,0, 3'h2,0);
        tbl[1]  = mk(0,0, 0,0,  0,0, 0,0,  1,0, 4,0, 3,0);
        tbl[2]  = mk(0,0, 0,0,  0,0, 0,0,  0,0, 4,0, 3,0);
        // mul held 4 cycles with an add every cycle: FIFO fills to DEPTH
        tbl[3]  = mk(1,1,10,0,  1,1,20,4,  1,1,10,0, 3,0);
        tbl[4]  = mk(1,1,11,0,  1,1,21,4,  1,1,11,0, 3,0);
        tbl[5]  = mk(1,1,12,0,  1,1,22,4,  1,1,12,1, 3,0);
        tbl[6]  = mk(1,1,13,0,  1,1,23,4,  1,1,13,1, 3,0);
        tbl[7]  = mk(0,0, 0,0,  0,0, 0,0,  1,1,20,1, 3,4);
        tbl[8]  = mk(0,0, 0,0,  0,0, 0,0,  1,1,21,0, 3,4);
        tbl[9]  = mk(0,0, 0,0,  0,0, 0,0,  1,1,22,0, 3,4);
        tbl[10] = mk(0,0, 0,0,  0,0, 0,0,  1,1,23,0, 3,4);
        tbl[11] = mk(0,0, 0,0,  0,0, 0,0,  0,1,23,0, 3,4);
        // new adds behind two buffered adds must not overtake
        tbl[12] = mk(1,0,14,0,  1,0,24,0,  1,0,14,0, 3,4);
        tbl[13] = mk(1,0,15,0,  1,0,25,0,  1,0,15,0, 3,4);
        tbl[14] = mk(0,0, 0,0,  1,0,26,0,  1,0,24,0, 3,4);
        tbl[15] = mk(0,0, 0,0,  1,0,27,0,  1,0,25,0, 3,4);
        tbl[16] = mk(0,0, 0,0,  0,0, 0,0,  1,0,26,0, 3,4);
        tbl[17] = mk(0,0, 0,0,  0,0, 0,0,  1,0,27,0, 3,4);
        tbl[18] = mk(0,0, 0,0,  0,0, 0,0,  0,0,27,0, 3,4);
    end

    // ---------------- main sequence ----------------
    initial begin
        idle();
        reset = 1;
        model_reset();
        #1;
        check("reset.wb_valid", 64'(wb_valid), 0);
        check("reset.wb_res", wb_res, 0);
        check("reset.add_stall", 64'(add_stall), 0);
        check("reset.fflags_0", 64'(fflags_0), 0);
        do_reset();
        check_model("post_reset");

        // single uncontended add
        add_valid = 1; add_hart = 0; add_rd = 5;
        add_res = 64'hffffffff_3f800000; add_flags = 5'h01;
        tick();
        idle();
`ifdef FP_WB_BYPASS_EN
        check("single.wb_valid", 64'(wb_valid), 1);
        check("single.wb_rd", 64'(wb_rd), 5);
        check("single.wb_res", wb_res, 64'hffffffff_3f800000);
        check("single.fflags_0", 64'(fflags_0), 1);
        tick();
        check("single.after", 64'(wb_valid), 0);
`else
        check("single.wb_valid_early", 64'(wb_valid), 0);
        tick();
        check("single.wb_valid", 64'(wb_valid), 1);
        check("single.wb_rd", 64'(wb_rd), 5);
        check("single.wb_res", wb_res, 64'hffffffff_3f800000);
        check("single.fflags_0", 64'(fflags_0), 1);
`endif

        // vector table
        do_reset();
        for (int i = 0; i < 19; i++) begin
            idle();
            mul_valid = tbl[i].mv; mul_hart = tbl[i].mh; mul_rd = tbl[i].mrd;
            mul_res = resv(int'(tbl[i].mrd)); mul_flags = tbl[i].mf;
            add_valid = tbl[i].av; add_hart = tbl[i].ah; add_rd = tbl[i].ard;
            add_res = resv(int'(tbl[i].ard)); add_flags = tbl[i].af;
            tick();
            check($sformatf("tbl%0d.wb_valid", i), 64'(wb_valid), 64'(tbl[i].ev));
            check($sformatf("tbl%0d.wb_hart", i), 64'(wb_hart), 64'(tbl[i].eh));
            check($sformatf("tbl%0d.wb_rd", i), 64'(wb_rd), 64'(tbl[i].erd));
            check($sformatf("tbl%0d.wb_res", i), wb_res, resv(int'(tbl[i].erd)));
            check($sformatf("tbl%0d.add_stall", i), 64'(add_stall), 64'(tbl[i].es));
            check($sformatf("tbl%0d.fflags_0", i), 64'(fflags_0), 64'(tbl[i].ef0));
            check($sformatf("tbl%0d.fflags_1", i), 64'(fflags_1), 64'(tbl[i].ef1));
        end

        // CSR write alone, then CSR write coinciding with a hart1 retirement
        idle();
        csr_we = 1; csr_hart = 1; csr_data = 5'h1b;
        tick();
        check("csr.fflags_1", 64'(fflags_1), 5'h1b);
        check("csr.fflags_0", 64'(fflags_0), 5'h03);
        idle();
        mul_valid = 1; mul_hart = 1; mul_rd = 30; mul_res = resv(30); mul_flags = 5'h04;
        csr_we = 1; csr_hart = 1; csr_data = 5'h00;
        tick();
        idle();
        check("csr_wb.fflags_1", 64'(fflags_1), 5'h04);
        check("csr_wb.fflags_0", 64'(fflags_0), 5'h03);
        check("csr_wb.wb_rd", 64'(wb_rd), 30);
        check("csr_wb.wb_hart", 64'(wb_hart), 1);

        // asynchronous reset with three adds buffered
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mul_valid = 1; mul_hart = 1'(i); mul_rd = 6'(40 + i); mul_res = resv(40 + i);
            mul_flags = 5'h02;
            add_valid = 1; add_hart = 0; add_rd = 6'(50 + i); add_res = resv(50 + i);
            add_flags = 5'h08;
            tick();
        end
        idle();
        check_model("prerst");
        #2;
        reset = 1;
        #1;
        check("midrst.wb_valid", 64'(wb_valid), 0);
        check("midrst.wb_hart", 64'(wb_hart), 0);
        check("midrst.wb_rd", 64'(wb_rd), 0);
        check("midrst.wb_res", wb_res, 0);
        check("midrst.add_stall", 64'(add_stall), 0);
        check("midrst.fflags_0", 64'(fflags_0), 0);
        check("midrst.fflags_1", 64'(fflags_1), 0);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_model($sformatf("postrst%0d", i));
        end

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle();
            mul_valid = ($urandom_range(0, 99) < 35);
            add_valid = ($urandom_range(0, 99) < 55);
            if (mul_valid && add_valid && pend.size() >= DEPTH) add_valid = 0;
            mul_hart = 1'($urandom); mul_rd = 6'($urandom); mul_flags = 5'($urandom);
            mul_res = {$urandom, $urandom};
            add_hart = 1'($urandom); add_rd = 6'($urandom); add_flags = 5'($urandom);
            add_res = {$urandom, $urandom};
            csr_we = ($urandom_range(0, 99) < 8);
            csr_hart = 1'($urandom); csr_data = 5'($urandom);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
